// File: rtl/inst_loader.sv
// Boot-time program loader: takes a length/words/checksum byte stream, writes the
// words into instruction memory, and holds the core in reset until a load checks out.
module inst_loader #(
  parameter int ADDR_W      = 7,
  parameter int MAX_WORDS   = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_wen,
  output logic              core_rst,
  output logic              core_enb,
  output logic              done,
  output logic              err,
  output logic [7:0]        words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       asm_q, asm_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_wen_q, inst_wen_d;
  logic              core_rst_q, core_rst_d;
  logic              core_enb_q, core_enb_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        words_loaded_q, words_loaded_d;
  logic              accept;
  logic              tmo_hit;

  assign byte_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept       = byte_valid & byte_ready;
  assign tmo_hit      = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  assign inst_data    = inst_data_q;
  assign inst_addr    = inst_addr_q;
  assign inst_wen     = inst_wen_q;
  assign core_rst     = core_rst_q;
  assign core_enb     = core_enb_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

  // Next-state and registered-output decode for the load sequence.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    xor_d          = xor_q;
    asm_d          = asm_q;
    tmo_d          = tmo_q;
    inst_data_d    = inst_data_q;
    inst_addr_d    = inst_addr_q;
    inst_wen_d     = 1'b0;
    core_rst_d     = core_rst_q;
    core_enb_d     = core_enb_q;
    done_d         = done_q;
    err_d          = err_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      S_LEN: begin
        if (accept) begin
          n_d = byte_in;
          if ((byte_in == 8'd0) || ({1'b0, byte_in} > 9'(MAX_WORDS))) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            idx_d   = 8'd0;
            cnt_d   = 2'd0;
            xor_d   = 8'd0;
            tmo_d   = '0;
          end
        end else begin
          state_d = S_LEN;
        end
      end

      S_DATA: begin
        if (accept) begin
          asm_d[{cnt_q, 3'b000} +: 8] = byte_in;
          xor_d = xor_q ^ byte_in;
          tmo_d = '0;
          if (cnt_q == 2'd3) begin
            // Word complete: strobe it out on the next cycle while WRITE is held.
            state_d        = S_WRITE;
            cnt_d          = 2'd0;
            inst_wen_d     = 1'b1;
            inst_addr_d    = ADDR_W'(idx_q);
            inst_data_d    = asm_d;
            words_loaded_d = words_loaded_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_WRITE: begin
        tmo_d = '0;
        if (idx_q == (n_q - 8'd1)) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
          idx_d   = idx_q + 8'd1;
          cnt_d   = 2'd0;
        end
      end

      S_CSUM: begin
        if (accept) begin
          tmo_d = '0;
          if (byte_in == xor_q) begin
            state_d    = S_RUN;
            core_rst_d = 1'b0;
            core_enb_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_RUN, S_ERR: begin
        if (reload) begin
          state_d        = S_LEN;
          core_rst_d     = 1'b1;
          core_enb_d     = 1'b0;
          done_d         = 1'b0;
          err_d          = 1'b0;
          words_loaded_d = 8'd0;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d    = S_ERR;
        err_d      = 1'b1;
        core_rst_d = 1'b1;
        core_enb_d = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LEN;
      n_q            <= 8'd0;
      idx_q          <= 8'd0;
      cnt_q          <= 2'd0;
      xor_q          <= 8'd0;
      asm_q          <= 32'd0;
      tmo_q          <= '0;
      inst_data_q    <= 32'd0;
      inst_addr_q    <= '0;
      inst_wen_q     <= 1'b0;
      core_rst_q     <= 1'b1;
      core_enb_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      xor_q          <= xor_d;
      asm_q          <= asm_d;
      tmo_q          <= tmo_d;
      inst_data_q    <= inst_data_d;
      inst_addr_q    <= inst_addr_d;
      inst_wen_q     <= inst_wen_d;
      core_rst_q     <= core_rst_d;
      core_enb_q     <= core_enb_d;
      done_q         <= done_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a stream-level model predicts the IMEM writes
// and final status of each load.
module tb_inst_loader;

  localparam int ADDR_W    = 7;
  localparam int MAX_WORDS = 128;
  localparam int TMO       = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              reload;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_wen;
  logic              core_rst;
  logic              core_enb;
  logic              done;
  logic              err;
  logic [7:0]        words_loaded;

  inst_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (MAX_WORDS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .reload       (reload),
    .inst_data    (inst_data),
    .inst_addr    (inst_addr),
    .inst_wen     (inst_wen),
    .core_rst     (core_rst),
    .core_enb     (core_enb),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  bit          mon_en = 1'b0;
  int          ready_low = 0;
  int          wen_double = 0;
  logic        prev_wen = 1'b0;
  logic [31:0] stim_words [0:255];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write / handshake monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (inst_wen) begin
        wr_addr.push_back(int'(inst_addr));
        wr_data.push_back(inst_data);
      end
      if (inst_wen && prev_wen) wen_double++;
      if (!byte_ready && !done && !err) ready_low++;
    end
    prev_wen = inst_wen;
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (byte_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_inst_addr", inst_addr, 0);
    check_eq("rst_inst_wen", inst_wen, 0);
    check_eq("rst_core_rst", core_rst, 1);
    check_eq("rst_core_enb", core_enb, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_words_loaded", words_loaded, 0);
    check_eq("rst_byte_ready", byte_ready, 1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_eq("reload_err", err, 0);
    check_eq("reload_done", done, 0);
    check_eq("reload_core_rst", core_rst, 1);
    check_eq("reload_core_enb", core_enb, 0);
    check_eq("reload_words_loaded", words_loaded, 0);
    check_eq("reload_byte_ready", byte_ready, 1);
  endtask

  // One complete load; the model: legal length writes every word in order,
  // and the run is good only if the checksum byte equals the XOR of the data bytes.
  task automatic run_load(input logic [7:0] len, input logic [7:0] csum_mask, input int max_gap,
                          input int stall_idx, input int stall_len);
    bit         legal;
    bit         exp_ok;
    bit         ok;
    logic [7:0] good_csum;
    int         exp_n;
    int         k;
    int         gap;
    legal  = (len != 8'd0) && (int'(len) <= MAX_WORDS);
    exp_n  = legal ? int'(len) : 0;
    exp_ok = legal && (csum_mask == 8'd0);
    good_csum = 8'd0;
    for (int i = 0; i < exp_n; i++)
      for (int b = 0; b < 4; b++) good_csum = good_csum ^ stim_words[i][8*b +: 8];

    wr_addr.delete();
    wr_data.delete();
    ready_low  = 0;
    wen_double = 0;
    mon_en     = 1'b1;

    send_byte(len, int'($urandom_range(max_gap, 0)), ok);
    check_eq("len_accept", ok, 1);
    k = 0;
    if (legal) begin
      for (int i = 0; i < exp_n; i++) begin
        for (int b = 0; b < 4; b++) begin
          gap = (k == stall_idx) ? stall_len : int'($urandom_range(max_gap, 0));
          send_byte(stim_words[i][8*b +: 8], gap, ok);
          if (!ok) check_eq("data_accept", ok, 1);
          k++;
        end
      end
      send_byte(good_csum ^ csum_mask, int'($urandom_range(max_gap, 0)), ok);
      check_eq("csum_accept", ok, 1);
    end

    check_eq("done", done, exp_ok);
    check_eq("err", err, !exp_ok);
    check_eq("core_rst", core_rst, !exp_ok);
    check_eq("core_enb", core_enb, exp_ok);
    check_eq("ready_after", byte_ready, 0);
    mon_en = 1'b0;

    check_eq("n_writes", wr_addr.size(), exp_n);
    for (int i = 0; i < wr_addr.size() && i < exp_n; i++) begin
      check_eq("wr_addr", wr_addr[i], i);
      check_eq("wr_data", wr_data[i], stim_words[i]);
    end
    check_eq("words_loaded", words_loaded, exp_n);
    check_eq("ready_low_cycles", ready_low, exp_n);
    check_eq("wen_single_pulse", wen_double, 0);
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0] mask;
    rst = 1'b1;
    reload = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    // single word 0x13
    stim_words[0] = 32'h0000_0013;
    run_load(8'd1, 8'd0, 0, -1, 0);
    do_reload();

    // three words, back-to-back valid
    for (int i = 0; i < 3; i++) stim_words[i] = $urandom;
    run_load(8'd3, 8'd0, 0, -1, 0);
    do_reload();

    // bad checksum 0x12 for word 0x13
    stim_words[0] = 32'h0000_0013;
    run_load(8'd1, 8'h01, 0, -1, 0);
    do_reload();

    // illegal lengths
    run_load(8'h00, 8'd0, 0, -1, 0);
    do_reload();
    run_load(8'h81, 8'd0, 0, -1, 0);
    do_reload();

    // stall one short of the timeout before the 3rd data byte
    for (int i = 0; i < 2; i++) stim_words[i] = $urandom;
    run_load(8'd2, 8'd0, 0, 2, TMO - 1);
    do_reload();

    // full timeout after the 2nd data byte
    send_byte(8'd1, 0, ok);
    send_byte(8'hAA, 0, ok);
    send_byte(8'hBB, 0, ok);
    repeat (TMO - 1) @(negedge clk);
    check_eq("tmo_edge_err", err, 0);
    check_eq("tmo_edge_ready", byte_ready, 1);
    @(negedge clk);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_ready", byte_ready, 0);
    check_eq("tmo_core_rst", core_rst, 1);
    check_eq("tmo_done", done, 0);
    do_reload();

    // reset in the middle of DATA, then a clean load
    send_byte(8'd3, 0, ok);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h40), 0, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    for (int i = 0; i < 2; i++) stim_words[i] = $urandom;
    run_load(8'd2, 8'd0, 1, -1, 0);
    do_reload();

    // randomized loads
    for (int it = 0; it < 25; it++) begin
      n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(255, 129)) : int'($urandom_range(12, 1));
      for (int i = 0; i < 256; i++) stim_words[i] = $urandom;
      mask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      run_load(8'(n), mask, 3, -1, 0);
      do_reload();
    end

    // largest legal length
    for (int i = 0; i < 128; i++) stim_words[i] = $urandom;
    run_load(8'd128, 8'd0, 1, -1, 0);
    do_reload();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
